// File: rtl/cpu3_pkg.sv
// Shared encodings for the 3-bit CPU: opcodes, ALU opcodes, sequencer states
// and instruction field positions.
package cpu3_pkg;

    localparam int DATA_W = 3;
    localparam int NUM_REGS = 4;
    localparam int REG_AW = 2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_SHL  = 2'b10;
    localparam logic [1:0] ALU_IDLE = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    function automatic logic is_alu_op(input logic [2:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_SHL);
    endfunction

    function automatic logic writes_rd(input logic [2:0] opc);
        return is_alu_op(opc) || (opc == OP_LDI) || (opc == OP_LD);
    endfunction

endpackage

// File: rtl/cpu3_regfile.sv
// 4 x 3-bit register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear.
module cpu3_regfile
    import cpu3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/cpu3_control_unit.sv
// Fetch/decode/execute/writeback sequencer for the 3-bit CPU. Drives the ALU,
// the instruction memory and the data memory; every output is registered.
module cpu3_control_unit
    import cpu3_pkg::*;
#(
    parameter int IW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [AW-1:0] dmem_addr,
    output logic [2:0]    dmem_wdata,
    output logic          dmem_we,
    input  logic [2:0]    dmem_rdata,
    output logic [2:0]    alu_a,
    output logic [2:0]    alu_b,
    output logic [1:0]    alu_op,
    input  logic [2:0]    alu_r,
    input  logic          alu_cf,
    input  logic          alu_sf,
    input  logic          alu_zf,
    output logic [2:0]    flags,
    output logic          halted
);

    state_t            state;
    logic [AW-1:0]     pc;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] result;
    logic              taken;

    logic [2:0]        opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [2:0]        imm;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rs_data;
    logic              rf_we;

    assign opc = ir[OPC_MSB:OPC_LSB];
    assign rd  = ir[RD_MSB:RD_LSB];
    assign rs  = ir[RS_MSB:RS_LSB];
    assign imm = ir[IMM_MSB:IMM_LSB];

    assign imem_addr = pc;
    assign rf_we     = (state == S_WB) && writes_rd(opc);

    cpu3_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rd),
        .ra_data (rd_data),
        .rb_addr (rs),
        .rb_data (rs_data),
        .wr_en   (rf_we),
        .wr_addr (rd),
        .wr_data (result)
    );

    // Memory and ALU strobes are set up at the end of DECODE so they are
    // already stable for the whole EXEC cycle, then dropped when EXEC ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            result     <= '0;
            taken      <= 1'b0;
            flags      <= 3'b000;
            halted     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= ALU_IDLE;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_we    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= imem_data;
                    pc    <= pc + AW'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    alu_a <= rd_data;
                    alu_b <= rs_data;
                    if (opc == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                        if (is_alu_op(opc)) begin
                            alu_op <= opc[1:0];
                        end
                        if (opc == OP_LD) begin
                            dmem_addr <= AW'(rs_data);
                        end
                        if (opc == OP_ST) begin
                            dmem_addr  <= AW'(rd_data);
                            dmem_wdata <= rs_data;
                            dmem_we    <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    alu_op  <= ALU_IDLE;
                    dmem_we <= 1'b0;
                    state   <= S_WB;
                    if (is_alu_op(opc)) begin
                        result <= alu_r;
                        flags  <= {alu_cf, alu_sf, alu_zf};
                    end else if (opc == OP_LDI) begin
                        result <= imm;
                    end else if (opc == OP_LD) begin
                        result <= dmem_rdata;
                    end else if (opc == OP_JZ) begin
                        taken <= flags[0];
                    end
                end
                S_WB: begin
                    if ((opc == OP_JZ) && taken) begin
                        pc <= AW'(imm);
                    end
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu3_control_unit.sv
// Directed-vector bench for cpu3_control_unit with a behavioural ALU,
// instruction ROM and data RAM around the sequencer.
module tb_cpu3_control_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] imem_addr;
    logic [7:0] imem_data;
    logic [2:0] dmem_addr;
    logic [2:0] dmem_wdata;
    logic       dmem_we;
    logic [2:0] dmem_rdata;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_op;
    logic [2:0] alu_r;
    logic       alu_cf;
    logic       alu_sf;
    logic       alu_zf;
    logic [2:0] flags;
    logic       halted;

    logic [7:0] imem [8];
    logic [2:0] dmem [8] = '{default: 3'd0};
    logic [3:0] alu_wide;

    int check_count = 0;
    int fail_count = 0;
    int we_count = 0;
    int we_base;

    cpu3_control_unit #(.IW(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_r      (alu_r),
        .alu_cf     (alu_cf),
        .alu_sf     (alu_sf),
        .alu_zf     (alu_zf),
        .flags      (flags),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    // Reference ALU: carry is bit 3 of the widened result (borrow for SUB).
    always_comb begin
        alu_wide = 4'd0;
        case (alu_op)
            2'b00: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10: alu_wide = {1'b0, alu_a} << alu_b;
            default: alu_wide = 4'd0;
        endcase
        alu_r  = alu_wide[2:0];
        alu_cf = (alu_op != 2'b11) && alu_wide[3];
        alu_sf = (alu_op != 2'b11) && alu_wide[2];
        alu_zf = (alu_op != 2'b11) && (alu_wide[2:0] == 3'd0);
    end

    always @(posedge clk) begin
        if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            we_count <= we_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Holds reset, loads the program (instruction 0 in the top byte) and
    // releases reset on a falling edge so the next rising edge ends FETCH.
    task automatic applyStimulus(input logic [63:0] prog);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            imem[i] = prog[63 - 8*i -: 8];
        end
        repeat (2) @(negedge clk);
        we_base = we_count;
        rst_n = 1'b1;
    endtask

    function automatic int reg_val(input int idx);
        return int'(dut.u_regfile.regs[idx]);
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) imem[i] = 8'hE0;

        // LDI R1,3 then HALTs
        applyStimulus(64'h6BE0E0E0_E0E0E0E0);
        checkOutput("rst_pc", int'(imem_addr), 0);
        checkOutput("rst_flags", int'(flags), 0);
        checkOutput("rst_halted", int'(halted), 0);
        checkOutput("rst_alu_op", int'(alu_op), 3);
        checkOutput("rst_dmem_we", int'(dmem_we), 0);
        checkOutput("rst_alu_a", int'(alu_a), 0);
        stepCycles(4);
        checkOutput("ldi_r1", reg_val(1), 3);
        checkOutput("ldi_pc", int'(imem_addr), 1);
        checkOutput("ldi_flags", int'(flags), 0);
        checkOutput("ldi_no_we", we_count - we_base, 0);

        // LDI R0,5; LDI R1,3; ADD R0,R1; SUB R0,R1; LDI R2,4; LDI R3,6; ST R2,R3; LD R0,R2
        applyStimulus(64'h656B0222_747EB684);
        stepCycles(4);
        checkOutput("a_r0_5", reg_val(0), 5);
        stepCycles(4);
        checkOutput("a_r1_3", reg_val(1), 3);
        stepCycles(2);
        checkOutput("add_op", int'(alu_op), 0);
        checkOutput("add_a", int'(alu_a), 5);
        checkOutput("add_b", int'(alu_b), 3);
        stepCycles(2);
        checkOutput("add_r0", reg_val(0), 0);
        checkOutput("add_flags", int'(flags), 3'b101);
        checkOutput("wb_alu_op_idle", int'(alu_op), 3);
        stepCycles(2);
        checkOutput("sub_op", int'(alu_op), 1);
        stepCycles(2);
        checkOutput("sub_r0", reg_val(0), 5);
        checkOutput("sub_flags", int'(flags), 3'b110);
        stepCycles(8);
        checkOutput("a_r2_4", reg_val(2), 4);
        checkOutput("a_r3_6", reg_val(3), 6);
        stepCycles(2);
        checkOutput("st_we", int'(dmem_we), 1);
        checkOutput("st_addr", int'(dmem_addr), 4);
        checkOutput("st_wdata", int'(dmem_wdata), 6);
        checkOutput("st_alu_idle", int'(alu_op), 3);
        stepCycles(1);
        checkOutput("st_we_drop", int'(dmem_we), 0);
        stepCycles(1);
        checkOutput("st_one_pulse", we_count - we_base, 1);
        checkOutput("st_mem", int'(dmem[4]), 6);
        stepCycles(4);
        checkOutput("ld_r0", reg_val(0), 6);
        checkOutput("ld_flags", int'(flags), 3'b110);
        checkOutput("pc_wrap", int'(imem_addr), 0);

        // LDI R0,3; LDI R1,3; SUB R0,R1; JZ 6; HALT; HALT; SUB R1,R0; JZ 2
        applyStimulus(64'h636B22C6_E0E028C2);
        stepCycles(12);
        checkOutput("b_sub_r0", reg_val(0), 0);
        checkOutput("b_sub_flags", int'(flags), 3'b001);
        stepCycles(4);
        checkOutput("jz_taken_pc", int'(imem_addr), 6);
        stepCycles(4);
        checkOutput("b_sub2_r1", reg_val(1), 3);
        checkOutput("b_sub2_flags", int'(flags), 0);
        stepCycles(4);
        checkOutput("jz_not_taken_wrap", int'(imem_addr), 0);
        checkOutput("b_halted", int'(halted), 0);

        // LDI R0,1; LDI R1,2; ADD R0,R1; HALT
        applyStimulus(64'h616A02E0_E0E0E0E0);
        stepCycles(12);
        checkOutput("c_add_r0", reg_val(0), 3);
        checkOutput("c_pc", int'(imem_addr), 3);
        stepCycles(1);
        checkOutput("halt_decode_low", int'(halted), 0);
        stepCycles(1);
        checkOutput("halt_high", int'(halted), 1);
        checkOutput("halt_pc", int'(imem_addr), 4);
        stepCycles(20);
        checkOutput("halt_stays", int'(halted), 1);
        checkOutput("halt_pc_hold", int'(imem_addr), 4);
        checkOutput("halt_r0", reg_val(0), 3);
        checkOutput("halt_r1", reg_val(1), 2);
        checkOutput("halt_flags", int'(flags), 0);
        checkOutput("halt_alu_idle", int'(alu_op), 3);
        checkOutput("halt_no_we", we_count - we_base, 0);

        // LDI R2,5; LDI R3,7; ST R2,R3 -- reset lands inside the store's EXEC
        applyStimulus(64'h757FB6E0_E0E0E0E0);
        stepCycles(10);
        checkOutput("d_st_we", int'(dmem_we), 1);
        checkOutput("d_st_addr", int'(dmem_addr), 5);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", int'(dmem_we), 0);
        checkOutput("mid_rst_pc", int'(imem_addr), 0);
        checkOutput("mid_rst_r2", reg_val(2), 0);
        checkOutput("mid_rst_r3", reg_val(3), 0);
        checkOutput("mid_rst_dmem_addr", int'(dmem_addr), 0);
        checkOutput("mid_rst_wdata", int'(dmem_wdata), 0);
        checkOutput("mid_rst_alu_a", int'(alu_a), 0);
        checkOutput("mid_rst_alu_b", int'(alu_b), 0);
        stepCycles(2);
        checkOutput("mid_rst_no_store", int'(dmem[5]), 0);
        checkOutput("mid_rst_no_pulse", we_count - we_base, 0);
        rst_n = 1'b1;
        stepCycles(4);
        checkOutput("restart_r2", reg_val(2), 5);
        checkOutput("restart_pc", int'(imem_addr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
